inst_assembler: RTL and testbench

Streaming RISC-V instruction encoder. It is the inverse of the immediate generator: it takes decoded fields plus a 32-bit immediate and packs them into a legal 32-bit instruction word. It sits on the debug/program-loader path, accepts field tuples over a valid/ready handshake, and emits encoded words with auto-incrementing word addresses toward instruction memory. Immediates that cannot be represented are range-checked and dropped.

---
 rtl/inst_assembler_pkg.sv | 74 +++++++
 rtl/inst_assembler_if.sv | 45 ++++
 rtl/inst_assembler_pack.sv | 68 ++++++
 rtl/inst_assembler.sv | 125 ++++++++++++
 tb/tb_inst_assembler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_assembler_pkg.sv
// -----------------------------------------------------------------------------
// inst_assembler_pkg
// Shared definitions for the RISC-V instruction assembler:
//   - IMM_* format codes (same encoding the decoder uses for its immediate
//     generator, so a tuple can be round-tripped through it unchanged)
//   - base opcode constants
//   - fields_t: one decoded field tuple as presented on the input stream
//   - fmt_e / classify_fmt: collapses the 3-bit format code to a format class
//   - fits_signed: "upper bits are a pure sign extension" range test
// -----------------------------------------------------------------------------
package inst_assembler_pkg;

    // Immediate format codes shared with the decoder's immediate generator.
    // Any code not listed here selects an R-type (register-register) word.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Base opcodes (inst[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    function automatic fmt_e classify_fmt(logic [2:0] code);
        fmt_e f;
        case (code)
            IMM_I:   f = FMT_I;
            IMM_S:   f = FMT_S;
            IMM_B:   f = FMT_B;
            IMM_U:   f = FMT_U;
            IMM_J:   f = FMT_J;
            default: f = FMT_R;
        endcase
        return f;
    endfunction

    // True when v[31:msb] are all equal, i.e. v is representable as a signed
    // (msb+1)-bit value. An arithmetic shift leaves all-zeros or all-ones
    // exactly in that case.
    function automatic logic fits_signed(logic [31:0] v, int unsigned msb);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_assembler_if.sv
// -----------------------------------------------------------------------------
// inst_assembler_if
// Stream interface of the instruction assembler.
//   Input stream  : in_valid / in_ready handshake carrying one field tuple
//                   (fmt, opcode, rd, rs1, rs2, funct3, funct7, imm).
//   Output stream : out_valid / out_ready handshake carrying the encoded word
//                   (out_data) and its instruction-memory word address.
// Modports:
//   slave  - the assembler (consumes tuples, produces words)
//   master - the producer/consumer side (program loader, memory writer)
// -----------------------------------------------------------------------------
interface inst_assembler_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;

    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready,
        output out_valid, out_addr, out_data,
        input  out_ready
    );

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready,
        input  out_valid, out_addr, out_data,
        output out_ready
    );

endinterface

// File: rtl/inst_assembler_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational RISC-V field packer: builds the 32-bit instruction word
// for one field tuple and reports whether its immediate is representable in
// the selected format.
// Ports:
//   i_fields  in   fields_t  decoded tuple (format code, registers, functs, imm)
//   o_word    out  32        encoded instruction word
//   o_legal   out  1         immediate fits the format (always 1 for R-type)
// -----------------------------------------------------------------------------
module inst_pack
    import inst_assembler_pkg::*;
(
    input  fields_t     i_fields,
    output logic [31:0] o_word,
    output logic        o_legal
);

    logic [31:0] w_imm;

    assign w_imm = i_fields.imm;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        o_word  = '0;
        o_legal = 1'b1;

        case (classify_fmt(i_fields.fmt))
            FMT_I: begin
                o_word  = {w_imm[11:0], i_fields.rs1, i_fields.funct3,
                           i_fields.rd, i_fields.opcode};
                o_legal = fits_signed(w_imm, 11);
            end
            FMT_S: begin
                o_word  = {w_imm[11:5], i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, w_imm[4:0], i_fields.opcode};
                o_legal = fits_signed(w_imm, 11);
            end
            FMT_B: begin
                // Branch offsets are in half-words: bit 0 is implicit and
                // must be zero, bit 12 is the sign.
                o_word  = {w_imm[12], w_imm[10:5], i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, w_imm[4:1], w_imm[11],
                           i_fields.opcode};
                o_legal = !w_imm[0] && fits_signed(w_imm, 12);
            end
            FMT_U: begin
                // The caller passes the full upper immediate; any set bit in
                // the low 12 bits would be silently lost.
                o_word  = {w_imm[31:12], i_fields.rd, i_fields.opcode};
                o_legal = (w_imm[11:0] == 12'h000);
            end
            FMT_J: begin
                o_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                           i_fields.rd, i_fields.opcode};
                o_legal = !w_imm[0] && fits_signed(w_imm, 20);
            end
            default: begin
                // R-type carries no immediate; imm is ignored.
                o_word  = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, i_fields.rd, i_fields.opcode};
                o_legal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_assembler.sv
// -----------------------------------------------------------------------------
// inst_assembler
// Streaming RISC-V instruction encoder for the debug/program-loader path.
// Accepts decoded field tuples, packs them into instruction words and emits
// them with auto-incrementing instruction-memory word addresses through a
// single output register stage. Tuples whose immediate does not fit their
// format are consumed but dropped, and raise a sticky error flag.
// Ports:
//   clk        in   1       rising-edge clock
//   rstn       in   1       synchronous active-low reset
//   bus        slave        tuple input stream and word output stream
//   base_load  in   1       load the address counter from base_addr
//   base_addr  in   ADDR_W  new start address
//   err        out  1       sticky range error, cleared by err_clr
//   err_clr    in   1       clear err (a same-cycle new error wins)
//   wrap       out  1       sticky, set when the address counter wraps
// -----------------------------------------------------------------------------
module inst_assembler
    import inst_assembler_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter int unsigned BASE_RST = 0
) (
    input  logic              clk,
    input  logic              rstn,
    inst_assembler_if.slave   bus,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              err,
    input  logic              err_clr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(BASE_RST);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    fields_t           w_fields;
    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_in_ready;
    logic              w_fire;
    logic              w_load;
    logic              w_reject;

    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_err;
    logic              r_wrap;

    assign w_fields = '{
        fmt:    bus.fmt,
        opcode: bus.opcode,
        rd:     bus.rd,
        rs1:    bus.rs1,
        rs2:    bus.rs2,
        funct3: bus.funct3,
        funct7: bus.funct7,
        imm:    bus.imm
    };

    inst_pack u_pack (
        .i_fields (w_fields),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // The single output register can take a new word whenever it is empty or
    // is being drained in this same cycle.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_fire     = bus.in_valid && w_in_ready;
    assign w_load     = w_fire && w_legal;
    assign w_reject   = w_fire && !w_legal;

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values; e.g. r_out_addr must see r_cnt before its
        // increment in the same edge.
        if (!rstn) begin
            // NOTE: the data/address register is reset too, not just the
            // valid bit, so nothing stale is visible right after reset.
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= ADDR_RST;
            r_cnt       <= ADDR_RST;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_addr  <= r_cnt;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A base load wins over the increment; the word loaded in the same
            // cycle has already latched the old counter value above.
            if (base_load) begin
                r_cnt <= base_addr;
            end else if (w_load) begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end

            if (w_load && !base_load && (r_cnt == ADDR_LAST)) begin
                r_wrap <= 1'b1;
            end

            if (w_reject) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_addr  = r_out_addr;
    assign err           = r_err;
    assign wrap          = r_wrap;

endmodule

// File: tb/tb_inst_assembler.sv
// -----------------------------------------------------------------------------
// tb_inst_assembler
// Self-checking bench for inst_assembler. Expected words are validated by
// decoding them back with a reference immediate generator and field
// extractor; legality is judged from plain integer ranges.
// -----------------------------------------------------------------------------
module tb_inst_assembler;
    import inst_assembler_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              err;
    logic              err_clr;
    logic              wrap;

    int n_checks;
    int n_fail;

    inst_assembler_if #(.ADDR_W(ADDR_W)) bus ();

    inst_assembler #(.ADDR_W(ADDR_W), .BASE_RST(0)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .base_load (base_load),
        .base_addr (base_addr),
        .err       (err),
        .err_clr   (err_clr),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ reference
    function automatic fields_t mk(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                                   logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                                   logic [6:0] f7, logic [31:0] imm);
        return '{fmt: fmt, opcode: op, rd: rd, rs1: rs1, rs2: rs2,
                 funct3: f3, funct7: f7, imm: imm};
    endfunction

    // Immediate generator as found in a RISC-V decoder.
    function automatic logic [31:0] ref_immgen(logic [31:0] w, logic [2:0] fmt);
        logic [31:0] r;
        case (fmt)
            IMM_I:   r = {{20{w[31]}}, w[31:20]};
            IMM_S:   r = {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_U:   r = {w[31:12], 12'b0};
            IMM_J:   r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Word decodes back to every field the format carries.
    function automatic bit ref_word_ok(logic [31:0] w, fields_t t);
        bit ok;
        bit imm_ok;
        ok     = (w[6:0] == t.opcode);
        imm_ok = (ref_immgen(w, t.fmt) == t.imm);
        case (t.fmt)
            IMM_I:   ok = ok && w[11:7] == t.rd && w[14:12] == t.funct3 && w[19:15] == t.rs1 && imm_ok;
            IMM_S,
            IMM_B:   ok = ok && w[14:12] == t.funct3 && w[19:15] == t.rs1 && w[24:20] == t.rs2 && imm_ok;
            IMM_U,
            IMM_J:   ok = ok && w[11:7] == t.rd && imm_ok;
            default: ok = ok && w[11:7] == t.rd && w[14:12] == t.funct3 && w[19:15] == t.rs1 &&
                          w[24:20] == t.rs2 && w[31:25] == t.funct7;
        endcase
        return ok;
    endfunction

    // Representable ranges expressed as integer intervals.
    function automatic bit ref_legal(fields_t t);
        longint v;
        v = longint'($signed(t.imm));
        case (t.fmt)
            IMM_I,
            IMM_S:   return v >= -2048 && v <= 2047;
            IMM_B:   return (v % 2 == 0) && v >= -4096 && v <= 4095;
            IMM_J:   return (v % 2 == 0) && v >= -(64'sd1 << 20) && v <= (64'sd1 << 20) - 1;
            IMM_U:   return (t.imm % 4096) == 0;
            default: return 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.fmt      = '0;
        bus.opcode   = '0;
        bus.rd       = '0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.funct3   = '0;
        bus.funct7   = '0;
        bus.imm      = '0;
    endtask

    task automatic drive_tuple(fields_t t);
        bus.in_valid = 1'b1;
        bus.fmt      = t.fmt;
        bus.opcode   = t.opcode;
        bus.rd       = t.rd;
        bus.rs1      = t.rs1;
        bus.rs2      = t.rs2;
        bus.funct3   = t.funct3;
        bus.funct7   = t.funct7;
        bus.imm      = t.imm;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        drive_idle();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        apply_reset();
        #2;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
        n_checks++; if (bus.out_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.out_addr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_i_type();
        bus.out_ready = 1'b1;
        drive_tuple(mk(IMM_I, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF));
        #2;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL i_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        drive_idle();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL i_valid: got %b expected 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'hFFF10093) begin n_fail++; $display("FAIL i_data: got %h expected fff10093", bus.out_data); end
        n_checks++; if (bus.out_addr !== 10'd0) begin n_fail++; $display("FAIL i_addr: got %h expected 0", bus.out_addr); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL i_err: got %b expected 0", err); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL i_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_b_type_err();
        bus.out_ready = 1'b1;
        drive_tuple(mk(IMM_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4));
        tick();
        drive_idle();
        n_checks++; if (bus.out_data !== 32'hFE208EE3) begin n_fail++; $display("FAIL b_data: got %h expected fe208ee3", bus.out_data); end
        n_checks++; if (bus.out_addr !== 10'd1) begin n_fail++; $display("FAIL b_addr: got %h expected 1", bus.out_addr); end
        // Out-of-range branch offset: consumed, dropped, flagged.
        drive_tuple(mk(IMM_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096));
        tick();
        drive_idle();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL b_range_err: got %b expected 1", err); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b_range_no_word: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'hFE208EE3) begin n_fail++; $display("FAIL b_range_hold: got %h expected fe208ee3", bus.out_data); end
        drive_tuple(mk(IMM_I, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
        tick();
        drive_idle();
        n_checks++; if (bus.out_addr !== 10'd2) begin n_fail++; $display("FAIL b_cnt_unchanged: got %h expected 2", bus.out_addr); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b expected 0", err); end
        // Clear and a new error in the same cycle: the error wins.
        err_clr = 1'b1;
        drive_tuple(mk(IMM_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd1));
        tick();
        drive_idle();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_clr_vs_new: got %b expected 1", err); end
        tick();
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr2: got %b expected 0", err); end
    endtask

    task automatic test_backpressure();
        fields_t tup[4];
        int sent;
        int consumed;
        int cyc;
        bit exp_valid;
        bit rdy;
        bit exp_ready;
        apply_reset();
        tup[0] = mk(IMM_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        tup[1] = mk(IMM_J, 7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2);
        tup[2] = mk(IMM_J, 7'h6F, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000F_FFFE);
        tup[3] = mk(IMM_J, 7'h6F, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
        sent = 0;
        consumed = 0;
        cyc = 0;
        while (consumed < 4 && cyc < 40) begin
            exp_valid = (sent > consumed);
            n_checks++; if (bus.out_valid !== exp_valid) begin n_fail++; $display("FAIL bp_valid c%0d: got %b expected %b", cyc, bus.out_valid, exp_valid); end
            if (exp_valid) begin
                n_checks++; if (bus.out_addr !== ADDR_W'(consumed)) begin n_fail++; $display("FAIL bp_addr c%0d: got %h expected %h", cyc, bus.out_addr, consumed); end
                n_checks++; if (!ref_word_ok(bus.out_data, tup[consumed])) begin n_fail++; $display("FAIL bp_word c%0d: got %h for imm %h", cyc, bus.out_data, tup[consumed].imm); end
                if (consumed == 0) begin
                    n_checks++; if (bus.out_data !== 32'h001000EF) begin n_fail++; $display("FAIL bp_j_const: got %h expected 001000ef", bus.out_data); end
                end
            end
            rdy = !(cyc >= 2 && cyc <= 4);
            bus.out_ready = rdy;
            if (sent < 4) drive_tuple(tup[sent]);
            else drive_idle();
            #2;
            exp_ready = !exp_valid || rdy;
            n_checks++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b expected %b", cyc, bus.in_ready, exp_ready); end
            if (exp_valid && rdy) consumed++;
            if (sent < 4 && exp_ready) sent++;
            tick();
            cyc++;
        end
        drive_idle();
        n_checks++; if (consumed != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", consumed); end
    endtask

    task automatic test_base_load_wrap();
        fields_t t;
        bus.out_ready = 1'b1;
        t = mk(IMM_I, 7'h13, 5'd5, 5'd6, 5'd0, 3'd1, 7'd0, 32'd100);
        drive_tuple(t);
        base_load = 1'b1;
        base_addr = 10'h3FE;
        tick();
        base_load = 1'b0;
        n_checks++; if (bus.out_addr !== 10'd4) begin n_fail++; $display("FAIL bl_old_addr: got %h expected 004", bus.out_addr); end
        n_checks++; if (!ref_word_ok(bus.out_data, t)) begin n_fail++; $display("FAIL bl_word: got %h for imm %h", bus.out_data, t.imm); end
        t.imm = 32'd101;
        drive_tuple(t);
        tick();
        n_checks++; if (bus.out_addr !== 10'h3FE) begin n_fail++; $display("FAIL bl_addr_3fe: got %h expected 3fe", bus.out_addr); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL bl_no_wrap: got %b expected 0", wrap); end
        t.imm = 32'd102;
        drive_tuple(t);
        tick();
        n_checks++; if (bus.out_addr !== 10'h3FF) begin n_fail++; $display("FAIL bl_addr_3ff: got %h expected 3ff", bus.out_addr); end
        t.imm = 32'd103;
        drive_tuple(t);
        tick();
        drive_idle();
        n_checks++; if (bus.out_addr !== 10'h000) begin n_fail++; $display("FAIL bl_addr_wrap: got %h expected 000", bus.out_addr); end
        n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL bl_wrap: got %b expected 1", wrap); end
        // base_load must not disturb a word held under backpressure.
        bus.out_ready = 1'b0;
        base_load = 1'b1;
        base_addr = 10'h100;
        tick();
        base_load = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 10'h000) begin n_fail++; $display("FAIL bl_held: got valid %b addr %h expected 1 000", bus.out_valid, bus.out_addr); end
        n_checks++; if (!ref_word_ok(bus.out_data, t)) begin n_fail++; $display("FAIL bl_held_word: got %h for imm %h", bus.out_data, t.imm); end
        bus.out_ready = 1'b1;
        t.imm = 32'd104;
        drive_tuple(t);
        tick();
        drive_idle();
        n_checks++; if (bus.out_addr !== 10'h100) begin n_fail++; $display("FAIL bl_new_base: got %h expected 100", bus.out_addr); end
    endtask

    task automatic test_random_roundtrip();
        fields_t t;
        fields_t m_t;
        bit      m_valid;
        int      m_addr;
        int      m_cnt;
        bit      m_err;
        bit      m_wrap;
        int      emitted;
        int      cyc;
        bit      rdy;
        bit      exp_ready;
        bit      fire;
        bit      lg;
        // Drain the word left by the previous test; known state afterwards.
        drive_idle();
        bus.out_ready = 1'b1;
        tick();
        m_valid = 1'b0;
        m_addr  = 0;
        m_t     = '0;
        m_cnt   = 'h101;
        m_err   = 1'b0;
        m_wrap  = 1'b1;
        emitted = 0;
        cyc     = 0;
        while (emitted < 10000 && cyc < 60000) begin
            n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, bus.out_valid, m_valid); end
            if (m_valid) begin
                n_checks++; if (bus.out_addr !== ADDR_W'(m_addr)) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h expected %h", cyc, bus.out_addr, m_addr); end
                n_checks++; if (!ref_word_ok(bus.out_data, m_t)) begin n_fail++; $display("FAIL rnd_roundtrip c%0d: got %h fmt %0d imm %h", cyc, bus.out_data, m_t.fmt, m_t.imm); end
            end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b expected %b", cyc, err, m_err); end
            n_checks++; if (wrap !== m_wrap) begin n_fail++; $display("FAIL rnd_wrap c%0d: got %b expected %b", cyc, wrap, m_wrap); end

            t = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 3'($urandom), 7'($urandom), $urandom);
            if ($urandom_range(0, 5) != 0) begin
                case (t.fmt)
                    IMM_I, IMM_S: t.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                    IMM_B:        t.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
                    IMM_J:        t.imm = 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
                    IMM_U:        t.imm = $urandom & 32'hFFFF_F000;
                    default:      ;
                endcase
            end
            if ($urandom_range(0, 3) != 0) drive_tuple(t);
            else drive_idle();
            rdy           = ($urandom_range(0, 3) != 0);
            bus.out_ready = rdy;
            base_load     = ($urandom_range(0, 199) == 0);
            base_addr     = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(DEPTH - 4, DEPTH - 1))
                                                        : ADDR_W'($urandom);
            err_clr       = ($urandom_range(0, 15) == 0);
            #2;
            exp_ready = !m_valid || rdy;
            n_checks++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", cyc, bus.in_ready, exp_ready); end

            fire = bus.in_valid && exp_ready;
            lg   = ref_legal(t);
            if (fire && lg) begin
                m_valid = 1'b1;
                m_t     = t;
                m_addr  = m_cnt;
                emitted++;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (base_load) begin
                m_cnt = int'(base_addr);
            end else if (fire && lg) begin
                if (m_cnt + 1 == DEPTH) m_wrap = 1'b1;
                m_cnt = (m_cnt + 1) % DEPTH;
            end
            if (fire && !lg) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            tick();
            cyc++;
        end
        drive_idle();
        base_load = 1'b0;
        err_clr   = 1'b0;
        n_checks++; if (emitted < 10000) begin n_fail++; $display("FAIL rnd_budget: got %0d words expected 10000", emitted); end
    endtask

    task automatic test_reset_midstream();
        fields_t t;
        bus.out_ready = 1'b1;
        drive_idle();
        tick();
        drive_tuple(mk(IMM_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0001_0000));
        tick();
        t = mk(IMM_S, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'd16);
        drive_tuple(t);
        bus.out_ready = 1'b0;
        tick();
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mid_pre_err: got %b expected 1", err); end
        n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL mid_pre_wrap: got %b expected 1", wrap); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        drive_idle();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_addr !== 10'd0) begin n_fail++; $display("FAIL mid_addr: got %h expected 0", bus.out_addr); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", bus.out_data); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected 0", err); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL mid_wrap: got %b expected 0", wrap); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rstn          = 1'b0;
        base_load     = 1'b0;
        base_addr     = '0;
        err_clr       = 1'b0;
        bus.out_ready = 1'b0;
        drive_idle();

        test_reset();
        test_i_type();
        test_b_type_err();
        test_backpressure();
        test_base_load_wrap();
        test_random_roundtrip();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
